// File: rtl/cpu_pkg.sv
// Shared widths, the zero-register index and the forwarding-source bundle
// used by the operand stage and its forwarding muxes.
package cpu_pkg;

  localparam int DW = 64;
  localparam int AW = 5;

  // Register 31 reads as zero and is never a forwarding target.
  localparam logic [AW-1:0] XZR = 5'd31;

  // One later pipeline stage as seen by a forwarding mux.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic          regWrite;
    logic [DW-1:0] data;
  } fwd_src_t;

  // A stage can supply a source only if it writes, targets that index,
  // and the index is not the zero register.
  function automatic logic src_match(input fwd_src_t src, input logic [AW-1:0] idx);
    return src.regWrite && (src.rd == idx) && (idx != XZR);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Resolves the value of one source register: zero register first, then the
// youngest in-flight producer (EX, MEM, WB), then the regfile read data.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  fwd_src_t      ex,
  input  logic          ex_load,
  input  fwd_src_t      mem,
  input  fwd_src_t      wb,
  output logic [DW-1:0] data
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // A load in EX has no result yet, so it never forwards; the operand stage
  // turns that case into a load-use bubble instead.
  assign ex_hit  = src_match(ex, idx) && !ex_load;
  assign mem_hit = src_match(mem, idx);
  assign wb_hit  = src_match(wb, idx);

  // Priority select of the forwarded value.
  always_comb begin
    data = rf_data;
    if (idx == XZR) begin
      data = '0;
    end else if (ex_hit) begin
      data = ex.data;
    end else if (mem_hit) begin
      data = mem.data;
    end else if (wb_hit) begin
      data = wb.data;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: forwards both sources, picks the ALU operands,
// detects load-use hazards and registers everything into EX.
// The struct-based forwarding bundles use the package widths, so DW and AW
// are expected to stay at their package values.
module operand_stage #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ReadData1,
  input  logic [DW-1:0] ReadData2,
  input  logic [AW-1:0] ReadRegister1,
  input  logic [AW-1:0] ReadRegister2,
  input  logic          idValid,
  input  logic [AW-1:0] idRd,
  input  logic          idRegWrite,
  input  logic          idMemRead,
  input  logic          idALUSrc,
  input  logic [DW-1:0] idImm,
  input  logic [AW-1:0] exRd,
  input  logic          exRegWrite,
  input  logic          exMemRead,
  input  logic [DW-1:0] exResult,
  input  logic [AW-1:0] memRd,
  input  logic          memRegWrite,
  input  logic [DW-1:0] memResult,
  input  logic [AW-1:0] wbRd,
  input  logic          wbRegWrite,
  input  logic [DW-1:0] wbData,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] opA,
  output logic [DW-1:0] opB,
  output logic [DW-1:0] storeData,
  output logic          exValidOut,
  output logic [AW-1:0] exRdOut,
  output logic          exRegWriteOut,
  output logic          exMemReadOut,
  output logic          hazard,
  output logic [15:0]   bubbleCount
);

  import cpu_pkg::fwd_src_t;
  import cpu_pkg::XZR;

  fwd_src_t      ex_src;
  fwd_src_t      mem_src;
  fwd_src_t      wb_src;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [DW-1:0] opb_sel;
  logic          ex_load_hit;

  // Bundle each later stage into a forwarding source.
  always_comb begin
    ex_src.rd        = exRd;
    ex_src.regWrite  = exRegWrite;
    ex_src.data      = exResult;
    mem_src.rd       = memRd;
    mem_src.regWrite = memRegWrite;
    mem_src.data     = memResult;
    wb_src.rd        = wbRd;
    wb_src.regWrite  = wbRegWrite;
    wb_src.data      = wbData;
  end

  fwd_mux u_fwd1 (
    .idx     (ReadRegister1),
    .rf_data (ReadData1),
    .ex      (ex_src),
    .ex_load (exMemRead),
    .mem     (mem_src),
    .wb      (wb_src),
    .data    (fwd1)
  );

  fwd_mux u_fwd2 (
    .idx     (ReadRegister2),
    .rf_data (ReadData2),
    .ex      (ex_src),
    .ex_load (exMemRead),
    .mem     (mem_src),
    .wb      (wb_src),
    .data    (fwd2)
  );

  // Load-use detection: the load in EX targets either source of a valid
  // instruction in decode. Both sources count even when opB is the immediate.
  always_comb begin
    ex_load_hit = exMemRead && exRegWrite && (exRd != XZR) &&
                  ((exRd == ReadRegister1) || (exRd == ReadRegister2));
    hazard      = idValid && ex_load_hit;
  end

  // Second ALU operand: immediate or forwarded register.
  always_comb begin
    opb_sel = idALUSrc ? idImm : fwd2;
  end

  // Qualifier registers; flush beats stall beats hazard beats normal load.
  // Write and load flags are gated by valid so a bubble can never write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exValidOut    <= 1'b0;
      exRegWriteOut <= 1'b0;
      exMemReadOut  <= 1'b0;
    end else if (flush) begin
      exValidOut    <= 1'b0;
      exRegWriteOut <= 1'b0;
      exMemReadOut  <= 1'b0;
    end else if (stall) begin
      exValidOut    <= exValidOut;
      exRegWriteOut <= exRegWriteOut;
      exMemReadOut  <= exMemReadOut;
    end else if (hazard) begin
      exValidOut    <= 1'b0;
      exRegWriteOut <= 1'b0;
      exMemReadOut  <= 1'b0;
    end else begin
      exValidOut    <= idValid;
      exRegWriteOut <= idValid && idRegWrite;
      exMemReadOut  <= idValid && idMemRead;
    end
  end

  // Data registers only move on a normal load; on flush or bubble their
  // content is irrelevant, so holding saves toggling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA       <= '0;
      opB       <= '0;
      storeData <= '0;
      exRdOut   <= '0;
    end else if (!flush && !stall && !hazard) begin
      opA       <= fwd1;
      opB       <= opb_sel;
      storeData <= fwd2;
      exRdOut   <= idRd;
    end
  end

  // Saturating count of bubbles actually inserted into EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbleCount <= '0;
    end else if (!flush && !stall && hazard && (bubbleCount != 16'hFFFF)) begin
      bubbleCount <= bubbleCount + 16'd1;
    end
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter: DW, default 64, operand and data width.
REQ-002 Parameter: AW, default 5, register index width; index 31 is XZR.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: ReadData1, ReadData2  input  DW each  regfile read-port data for the decoded instruction.
REQ-006 Port: ReadRegister1, ReadRegister2  input  AW each  source indices matching ReadData1/2.
REQ-007 Port: idValid, idRd, idRegWrite, idMemRead, idALUSrc  input  1/AW/1/1/1  decoded-instruction qualifiers.
REQ-008 Port: idImm  input  DW  sign-extended immediate.
REQ-009 Port: exRd, exRegWrite, exMemRead, exResult  input  AW/1/1/DW  EX-stage destination, write flag, load flag and ALU result.
REQ-010 Port: memRd, memRegWrite, memResult  input  AW/1/DW  MEM-stage destination, write flag and result.
REQ-011 Port: wbRd, wbRegWrite, wbData  input  AW/1/DW  writeback bus, also driving the regfile write port.
REQ-012 Port: stall, flush  input  1 each  downstream hold request; squash request.
REQ-013 Port: opA, opB, storeData  output  DW each  registered ALU operands and registered store data.
REQ-014 Port: exValidOut, exRdOut, exRegWriteOut, exMemReadOut  output  1/AW/1/1  registered qualifiers.
REQ-015 Port: hazard  output  1  combinational load-use stall request to fetch/decode.
REQ-016 Port: bubbleCount  output  16  saturating count of inserted bubbles.

Function
REQ-017 Forwarded source value shall be selected per source with priority EX, then MEM, then WB, then regfile data.
REQ-018 A source shall match a forwarding stage only when that stage's write flag is 1, its destination equals the source index, and the index is not 31.
REQ-019 A source index of 31 shall always yield 0, regardless of any forward or regfile value.
REQ-020 An EX match whose exMemRead=1 shall not forward; it shall raise hazard instead.
REQ-021 hazard shall be idValid AND exMemRead AND exRegWrite AND exRd!=31 AND exRd equals either source index.
REQ-022 Operand selection: opA = fwd1; opB = idImm when idALUSrc=1, else fwd2; storeData = fwd2 always.
REQ-023 Update priority at each clk edge: flush, then stall, then hazard, then normal load.
REQ-024 Flush: exValidOut, exRegWriteOut and exMemReadOut shall be 0; data registers are don't-care.
REQ-025 Stall (without flush): all output registers shall hold; hazard shall still be computed.
REQ-026 Hazard (without stall or flush): a bubble shall be inserted with all three qualifier outputs at 0, and bubbleCount shall increment.
REQ-027 Normal load: all outputs shall register their selected values; exValidOut shall equal idValid.
REQ-028 exRegWriteOut and exMemReadOut shall be 0 whenever exValidOut is 0.
REQ-029 Latency: exactly one cycle from inputs to outputs, with no combinational path from inputs to registered outputs.
REQ-030 bubbleCount shall saturate at 16'hFFFF with no wrap.

Reset
REQ-031 On reset assertion, all outputs except hazard shall clear to 0 immediately, independent of clk.
REQ-032 Reset mid-stall or mid-hazard shall discard the held instruction; the first edge after deassertion shall perform a normal load.

Structure
REQ-033 Package cpu_pkg shall hold DW, AW, the XZR index (5'd31), and a struct fwd_src_t {rd, regWrite, data}.
REQ-034 One sub-module, fwd_mux, shall resolve a single source; operand_stage shall instantiate it twice.

Verification
REQ-035 Scenario: ReadRegister1=3, exRd=3, exRegWrite=1, exResult=64'hAA, memRd=3, memResult=64'hBB -> opA=64'hAA next cycle.
REQ-036 Scenario: ReadRegister2=31, wbRd=31, wbRegWrite=1, wbData=64'hFF, idALUSrc=0 -> opB=0 and storeData=0.
REQ-037 Scenario: exMemRead=1, exRegWrite=1, exRd=5, ReadRegister1=5, idValid=1 -> hazard=1; next cycle exValidOut=0 and bubbleCount=1.
REQ-038 Scenario: wbRd=7, wbRegWrite=1, wbData=64'h1234, ReadRegister1=7, ReadData1=64'h0 -> opA=64'h1234.
REQ-039 Scenario: stall=1 for 3 cycles with changing inputs -> outputs constant; flush and stall together -> exValidOut=0.
REQ-040 Scenario: reset asserted between clk edges while stall=1 -> outputs 0 before the next edge; 70000 hazards -> bubbleCount=16'hFFFF.
